// File: rtl/arm7tdmi_mem_responder_pkg.sv
// Shared types and byte-enable constants for the data-bus memory responder.
// The misalignment helper is only referenced when ARM7TDMI_MEM_ABORT_EN is defined.
package arm7tdmi_mem_responder_pkg;

  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mem_state_t;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_HW_LO = 4'b0011;
  localparam logic [3:0] BE_HW_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;

  function automatic logic misaligned(input logic [3:0] be, input logic [1:0] addr_lo);
    return (((be == BE_HW_LO) || (be == BE_HW_HI)) && addr_lo[0]) ||
           ((be == BE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/arm7tdmi_mem_responder_if.sv
// Core data-bus bundle: the core is the master, the memory responder the slave.
// mem_abort exists only when ARM7TDMI_MEM_ABORT_EN is defined.
interface arm7tdmi_mem_responder_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
`ifdef ARM7TDMI_MEM_ABORT_EN
  logic        mem_abort;
`endif

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re, mem_be,
`ifdef ARM7TDMI_MEM_ABORT_EN
    input  mem_abort,
`endif
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re, mem_be,
`ifdef ARM7TDMI_MEM_ABORT_EN
    output mem_abort,
`endif
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/arm7tdmi_mem_array.sv
// Single-port 32-bit RAM with per-lane write enables, registered read and a full-word backdoor.
// On a same-word collision the core lanes override the backdoor word (later non-blocking write wins).
module arm7tdmi_mem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        wr_lane,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [31:0]       bd_wdata,
  output logic [31:0]       rdata
);

  logic [31:0] ram [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_wdata;
    for (int i = 0; i < 4; i++) begin
      if (wr_lane[i]) ram[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rdata <= '0;
    else if (rd_clr) rdata <= '0;
    else if (rd_en)  rdata <= ram[addr];
  end

endmodule

// File: rtl/arm7tdmi_mem_responder.sv
// Data-bus memory responder: one request at a time, WAIT_STATES extra cycles, one-cycle mem_ready.
// ARM7TDMI_MEM_ABORT_EN adds range/alignment abort reporting on mem_abort.
module arm7tdmi_mem_responder
  import arm7tdmi_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  arm7tdmi_mem_responder_if.slave  bus,
  input  logic                     bd_we,
  input  logic [ADDR_W-1:0]        bd_addr,
  input  logic [31:0]              bd_wdata
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  mem_state_t  state, next_state;
  logic [3:0]  cnt;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_be;
  logic        lat_we;
  logic        accept, commit, ready;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_be;
  logic        cur_we, abort_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MEM_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      MEM_IDLE: if (bus.mem_we || bus.mem_re) next_state = (WS == 4'd0) ? MEM_RESP : MEM_WAIT;
      MEM_WAIT: if (cnt == 4'd1) next_state = MEM_RESP;
      MEM_RESP: next_state = MEM_IDLE;
      default:  next_state = MEM_IDLE;
    endcase
  end

  always_comb begin
    ready  = 1'b0;
    accept = 1'b0;
    commit = 1'b0;
    case (state)
      MEM_IDLE: begin
        accept = bus.mem_we || bus.mem_re;
        commit = accept && (WS == 4'd0);
      end
      MEM_WAIT: commit = (cnt == 4'd1);
      MEM_RESP: ready  = 1'b1;
      default:  ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_we    <= 1'b0;
    end else if (accept) begin
      cnt       <= WS;
      lat_addr  <= bus.mem_addr;
      lat_wdata <= bus.mem_wdata;
      lat_be    <= bus.mem_be;
      lat_we    <= bus.mem_we;
    end else if (state == MEM_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // With zero wait states the commit edge is the accept edge, so the live bus is used directly.
  assign cur_addr  = (state == MEM_IDLE) ? bus.mem_addr  : lat_addr;
  assign cur_wdata = (state == MEM_IDLE) ? bus.mem_wdata : lat_wdata;
  assign cur_be    = (state == MEM_IDLE) ? bus.mem_be    : lat_be;
  assign cur_we    = (state == MEM_IDLE) ? bus.mem_we    : lat_we;

`ifdef ARM7TDMI_MEM_ABORT_EN
  logic abort_q;

  assign abort_c = (|cur_addr[31:ADDR_W+2]) || misaligned(cur_be, cur_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      abort_q <= 1'b0;
    else if (commit) abort_q <= abort_c;
  end

  assign bus.mem_abort = abort_q;
`else
  logic unused_addr_bits;

  assign abort_c          = 1'b0;
  assign unused_addr_bits = ^{cur_addr[31:ADDR_W+2], cur_addr[1:0]};
`endif

  arm7tdmi_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_lane  ((commit && cur_we && !abort_c) ? cur_be : 4'b0000),
    .rd_en    (commit && !cur_we),
    .rd_clr   (commit && !cur_we && abort_c),
    .addr     (cur_addr[ADDR_W+1:2]),
    .wdata    (cur_wdata),
    .bd_we    (bd_we),
    .bd_addr  (bd_addr),
    .bd_wdata (bd_wdata),
    .rdata    (bus.mem_rdata)
  );

  assign bus.mem_ready = ready;

endmodule

// File: tb/tb_arm7tdmi_mem_responder.sv
// Directed bench: one responder with no wait states, one with three, sharing reset and backdoor.
module tb_arm7tdmi_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [31:0] bd_wdata;
  int          n_chk  = 0;
  int          n_pass = 0;

  int          lat;
  logic [31:0] rd;
  logic        ab;
  logic        after;

  always #5 clk = ~clk;

  arm7tdmi_mem_responder_if bus0();
  arm7tdmi_mem_responder_if bus3();

  arm7tdmi_mem_responder #(.ADDR_W(12), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
  );

  arm7tdmi_mem_responder #(.ADDR_W(12), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_req(input int w, input logic we, input logic re, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (w == 0) begin
      bus0.mem_we = we; bus0.mem_re = re; bus0.mem_be = be;
      bus0.mem_addr = addr; bus0.mem_wdata = wdata;
    end else begin
      bus3.mem_we = we; bus3.mem_re = re; bus3.mem_be = be;
      bus3.mem_addr = addr; bus3.mem_wdata = wdata;
    end
  endtask

  function automatic logic get_rdy(input int w);
    return (w == 0) ? bus0.mem_ready : bus3.mem_ready;
  endfunction

  function automatic logic [31:0] get_rdata(input int w);
    return (w == 0) ? bus0.mem_rdata : bus3.mem_rdata;
  endfunction

  function automatic logic get_abort(input int w);
`ifdef ARM7TDMI_MEM_ABORT_EN
    return (w == 0) ? bus0.mem_abort : bus3.mem_abort;
`else
    return (w == 0) ? 1'b0 : 1'b0;
`endif
  endfunction

  task automatic bd_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // lat counts cycles after the accept edge until mem_ready is seen; 0 means it never came.
  task automatic xact(input int w, input logic we, input logic re, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic toggle,
                      output int lat_o, output logic [31:0] rd_o, output logic ab_o,
                      output logic after_o);
    @(negedge clk);
    set_req(w, we, re, be, addr, wdata);
    @(posedge clk);
    lat_o = 0; rd_o = '0; ab_o = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (get_rdy(w)) begin
        lat_o = i; rd_o = get_rdata(w); ab_o = get_abort(w);
        break;
      end
      if (toggle) set_req(w, we, re, be, addr ^ 32'h0000_0FF0, ~wdata);
    end
    set_req(w, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    after_o = get_rdy(w);
  endtask

  initial begin
    rst_n = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    set_req(0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    set_req(3, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("reset_ready0", {31'b0, bus0.mem_ready}, 32'h0);
    chk("reset_rdata0", bus0.mem_rdata, 32'h0);
    chk("reset_ready3", {31'b0, bus3.mem_ready}, 32'h0);
    chk("reset_rdata3", bus3.mem_rdata, 32'h0);
    chk("reset_abort0", {31'b0, get_abort(0)}, 32'h0);
    rst_n = 1'b1;

    // Halfword store into a cleared word
    bd_write(12'h800, 32'h0000_0000);
    xact(0, 1'b1, 1'b0, 4'b0011, 32'h2000, 32'h0000_BEEF, 1'b0, lat, rd, ab, after);
    chk("strh_latency", lat, 1);
    chk("strh_ready_pulse", {31'b0, after}, 32'h0);
    xact(0, 1'b0, 1'b1, 4'b1111, 32'h2000, 32'h0, 1'b0, lat, rd, ab, after);
    chk("strh_readback", rd, 32'h0000_BEEF);

    // Backdoor then load, rdata holds after the pulse
    bd_write(12'h801, 32'hCAFE_1234);
    xact(0, 1'b0, 1'b1, 4'b1111, 32'h2004, 32'h0, 1'b0, lat, rd, ab, after);
    chk("bd_load_latency", lat, 1);
    chk("bd_load_rdata", rd, 32'hCAFE_1234);
    chk("rdata_hold", bus0.mem_rdata, 32'hCAFE_1234);

    // Lane-masked stores
    bd_write(12'h801, 32'h1122_3344);
    xact(0, 1'b1, 1'b0, 4'b1100, 32'h2006, 32'hDEAD_0000, 1'b0, lat, rd, ab, after);
    xact(0, 1'b0, 1'b1, 4'b1111, 32'h2004, 32'h0, 1'b0, lat, rd, ab, after);
    chk("hw_hi_store", rd, 32'hDEAD_3344);
    xact(0, 1'b1, 1'b0, 4'b0010, 32'h2005, 32'h0000_AA00, 1'b0, lat, rd, ab, after);
    xact(0, 1'b0, 1'b1, 4'b1111, 32'h2004, 32'h0, 1'b0, lat, rd, ab, after);
    chk("byte1_store", rd, 32'hDEAD_AA44);

    // Empty byte enable still completes, writes nothing
    xact(0, 1'b1, 1'b0, 4'b0000, 32'h2004, 32'hFFFF_FFFF, 1'b0, lat, rd, ab, after);
    chk("be0_latency", lat, 1);
    xact(0, 1'b0, 1'b1, 4'b1111, 32'h2004, 32'h0, 1'b0, lat, rd, ab, after);
    chk("be0_no_write", rd, 32'hDEAD_AA44);

    // we and re together behave as a store; rdata keeps its old value
    xact(0, 1'b1, 1'b1, 4'b1111, 32'h2008, 32'h600D_F00D, 1'b0, lat, rd, ab, after);
    chk("we_re_rdata_kept", rd, 32'hDEAD_AA44);
    xact(0, 1'b0, 1'b1, 4'b1111, 32'h2008, 32'h0, 1'b0, lat, rd, ab, after);
    chk("we_re_stored", rd, 32'h600D_F00D);

    // Backdoor and core commit hit the same word on the same edge
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 4'b0001, 32'h2040, 32'h0000_00BB);
    bd_we = 1'b1; bd_addr = 12'h810; bd_wdata = 32'hAAAA_AAAA;
    @(negedge clk);
    bd_we = 1'b0;
    set_req(0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    chk("collide_ready", {31'b0, bus0.mem_ready}, 32'h1);
    xact(0, 1'b0, 1'b1, 4'b1111, 32'h2040, 32'h0, 1'b0, lat, rd, ab, after);
    chk("collide_merge", rd, 32'hAAAA_AABB);

    // Three wait states, address toggled during WAIT
    bd_write(12'h820, 32'h1357_9BDF);
    bd_write(12'hBDC, 32'hFFFF_FFFF);
    xact(3, 1'b0, 1'b1, 4'b1111, 32'h2080, 32'h0, 1'b1, lat, rd, ab, after);
    chk("ws3_latency", lat, 4);
    chk("ws3_latched_addr", rd, 32'h1357_9BDF);
    chk("ws3_ready_pulse", {31'b0, after}, 32'h0);

    // Reset during WAIT of a store
    bd_write(12'h804, 32'h5A5A_5A5A);
    @(negedge clk);
    set_req(3, 1'b1, 1'b0, 4'b1111, 32'h2010, 32'hFFFF_0000);
    @(negedge clk);
    set_req(3, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready_a", {31'b0, bus3.mem_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_mid_ready_b", {31'b0, bus3.mem_ready}, 32'h0);
    end
    xact(3, 1'b0, 1'b1, 4'b1111, 32'h2010, 32'h0, 1'b0, lat, rd, ab, after);
    chk("rst_mid_idle_latency", lat, 4);
    chk("rst_mid_word_kept", rd, 32'h5A5A_5A5A);

`ifdef ARM7TDMI_MEM_ABORT_EN
    xact(0, 1'b0, 1'b1, 4'b1111, 32'h0001_2000, 32'h0, 1'b0, lat, rd, ab, after);
    chk("abort_range_flag", {31'b0, ab}, 32'h1);
    chk("abort_range_rdata", rd, 32'h0);
    xact(0, 1'b1, 1'b0, 4'b1111, 32'h2002, 32'h1234_5678, 1'b0, lat, rd, ab, after);
    chk("abort_word_misalign", {31'b0, ab}, 32'h1);
    xact(0, 1'b1, 1'b0, 4'b0011, 32'h2001, 32'h0000_5555, 1'b0, lat, rd, ab, after);
    chk("abort_hw_misalign", {31'b0, ab}, 32'h1);
    xact(0, 1'b0, 1'b1, 4'b1111, 32'h2000, 32'h0, 1'b0, lat, rd, ab, after);
    chk("abort_clear", {31'b0, ab}, 32'h0);
    chk("abort_mem_unchanged", rd, 32'h0000_BEEF);
`else
    xact(0, 1'b0, 1'b1, 4'b1111, 32'h0001_2000, 32'h0, 1'b0, lat, rd, ab, after);
    chk("wrap_latency", lat, 1);
    chk("wrap_rdata", rd, 32'h0000_BEEF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
